// File: rtl/ysyx_22050612_mem_responder_if.sv
// Request/response bus between a requester (master) and the memory responder (slave).
// One outstanding request at a time; the response is held until rsp_ready.
interface ysyx_22050612_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ysyx_22050612_mem_responder.sv
// Fixed-latency 64-bit word memory responder: accepts one request, waits LATENCY
// cycles, commits/samples memory, then holds the response until it is taken.
module ysyx_22050612_mem_responder #(
    parameter logic [63:0] ADDR_BASE  = 64'h8000_0000,
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    ysyx_22050612_mem_responder_if.slave        bus
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [63:0] WORDS    = 64'(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [3:0]            cnt;
    logic [3:0]            cnt_next;
    logic                  accept;
    logic                  commit;

    logic                  lat_wen;
    logic [63:0]           lat_addr;
    logic [63:0]           lat_wdata;
    logic [7:0]            lat_wmask;

    logic [63:0]           rdata;
    logic                  err;

    logic [63:0]           offset;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;

    logic [63:0]           mem [DEPTH];

    // Range test on the offset avoids overflow of ADDR_BASE + size near 2^64.
    assign offset   = lat_addr - ADDR_BASE;
    assign in_range = (lat_addr >= ADDR_BASE) && ((offset >> 3) < WORDS);
    assign idx      = offset[DEPTH_LOG2+2:3];

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata;
    assign bus.rsp_err   = err;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                    cnt_next   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    commit     = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_wen   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wmask <= '0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                lat_wen   <= bus.req_wen;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
                lat_wmask <= bus.req_wmask;
            end
            if (commit) begin
                err   <= !in_range;
                rdata <= (in_range && !lat_wen) ? mem[idx] : '0;
            end
        end
    end

    // Storage has no reset; commit is only raised from BUSY, which reset leaves.
    always_ff @(posedge clk) begin
        if (commit && in_range && lat_wen) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (lat_wmask[i]) begin
                    mem[idx][i*8 +: 8] <= lat_wdata[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: doc/ysyx_22050612_mem_responder.md
YSYX_22050612_MEM_RESPONDER -- requirements
Module: ysyx_22050612_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 64'h8000_0000, meaning the byte address of word 0.
REQ-002 SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of the number of 64-bit words stored (256 words, 2 KiB).
REQ-003 SHALL have parameter LATENCY, default 2, legal range 1..15, meaning the cycles from request acceptance to rsp_valid.
REQ-004 clk  in  1  single clock, all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  in  1  requester presents a request.
REQ-007 req_ready  out  1  responder accepts a request this cycle.
REQ-008 req_wen  in  1  1 = store, 0 = load.
REQ-009 req_addr  in  64  byte address; bits [2:0] are ignored.
REQ-010 req_wdata  in  64  store data, already lane-aligned by the requester.
REQ-011 req_wmask  in  8  store byte-enable, bit i enables byte lane i.
REQ-012 rsp_valid  out  1  response present.
REQ-013 rsp_ready  in  1  requester accepts the response.
REQ-014 rsp_rdata  out  64  full aligned word for a load; 0 for a store.
REQ-015 rsp_err  out  1  the address was out of range.

Function
REQ-016 SHALL implement an FSM with states IDLE, BUSY and RESP; req_ready = (state == IDLE) and rsp_valid = (state == RESP).
REQ-017 A request SHALL be accepted on a rising edge with req_valid && req_ready: latch wen, addr, wdata and wmask; enter BUSY; load the counter with LATENCY-1.
REQ-018 In BUSY, the counter SHALL decrement each cycle; when it is 0 at an edge, the state SHALL move to RESP, so rsp_valid rises exactly LATENCY edges after the acceptance edge.
REQ-019 LATENCY = 1 SHALL give RESP on the edge after acceptance, with BUSY lasting one cycle and the counter preloaded with 0.
REQ-020 Word index SHALL be (addr - ADDR_BASE) >> 3; the address is in range iff ADDR_BASE <= addr < ADDR_BASE + 8 * 2^DEPTH_LOG2, using 64-bit unsigned compare with no wrap-around.
REQ-021 For an in-range store, on the BUSY-to-RESP edge, each byte lane i with wmask[i] = 1 SHALL take wdata lane i; other lanes SHALL be unchanged; rsp_rdata = 0.
REQ-022 A store with wmask = 0 SHALL leave memory unchanged and SHALL respond normally.
REQ-023 For an in-range load, rsp_rdata SHALL be the word content sampled on the BUSY-to-RESP edge, so any earlier completed store is visible.
REQ-024 An out-of-range request SHALL not modify memory and SHALL respond with rsp_err = 1 and rsp_rdata = 0.
REQ-025 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until an edge with rsp_ready = 1; that edge SHALL return the state to IDLE.
REQ-026 There is one outstanding request at most; req_ready is 0 during BUSY and RESP.
REQ-027 The minimum request-to-request spacing is LATENCY + 2 cycles (one idle bubble after the response handshake).
REQ-028 Request inputs SHALL be ignored outside IDLE; the latched copy alone drives the transaction.

Reset
REQ-029 On rst_n = 0, the state SHALL go to IDLE, the counter to 0, rsp_valid to 0, rsp_rdata to 0 and rsp_err to 0; req_ready is therefore 1, both during reset and after release.
REQ-030 Reset during BUSY or RESP SHALL drop the pending transaction; a store not yet committed SHALL never be written.
REQ-031 Storage contents SHALL NOT be cleared by reset.

Verification
REQ-032 Reset check: assert rst_n low mid-BUSY on a pending store to 0x80000010 -> rsp_valid = 0 and req_ready = 1 immediately; a later read of 0x80000010 returns its prior value.
REQ-033 Full write and read (LATENCY = 2): store 0x80000008 / 0x1122334455667788 / mask 0xFF, then load 0x80000008 -> rsp_rdata = 0x1122334455667788; rsp_valid rises exactly 2 edges after each acceptance.
REQ-034 Byte merge: after REQ-033, store 0x8000000A with data 0x0000000000AA0000 and mask 0x04, then load 0x80000008 -> rsp_rdata = 0x1122334455AA7788, rsp_err = 0.
REQ-035 Backpressure: hold rsp_ready = 0 for 3 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable; req_ready = 0 even with req_valid = 1; after the handshake edge, req_ready = 1.
REQ-036 Range boundaries: store to 0x7FFFFFF8 and to 0x80000800 -> rsp_err = 1, rsp_rdata = 0; load 0x800007F8 -> rsp_err = 0; memory unchanged by the rejected stores.
REQ-037 LATENCY = 1 build: back-to-back requests with rsp_ready tied to 1 -> one response every 3 cycles and data correct.
